uart_bus_responder: RTL and testbench

- Byte-level command responder on the far side of the existing 8N1 UART: consumes received bytes, decodes host read/write commands and executes 32-bit Wishbone classic cycles.
- Returns the result to the host through the UART transmit handshake.
- Sits between the UART core and the debug/loader Wishbone master port.

---
 rtl/uart_bus_pkg.sv | 19 +
 rtl/uart_bus_responder.sv | 169 ++++++++++++++++
 tb/tb_uart_bus_responder.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_pkg.sv
// Shared constants and state encoding for the UART-to-Wishbone command responder.
package uart_bus_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] RSP_OK      = 8'h2E;
  localparam logic [7:0] RSP_BUS_ERR = 8'h21;
  localparam logic [7:0] RSP_BAD_CMD = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    TX_LOAD,
    TX_WAIT
  } state_e;

endpackage

// File: rtl/uart_bus_responder.sv
// Decodes host 'W'/'R' commands arriving byte-wise from the UART, runs one
// Wishbone classic cycle per command and streams the response back out.
module uart_bus_responder
  import uart_bus_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 5000000,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_received,
  input  logic [7:0]  rx_byte,
  input  logic        rx_error,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam int unsigned GAP_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned BUS_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);
  localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TIMEOUT - 1);

  state_e             state_q;
  logic               is_write_q;
  logic [1:0]         idx_q;
  logic [GAP_W-1:0]   gap_q;
  logic [BUS_W-1:0]   bus_cnt_q;
  logic [31:0]        shift_q;
  logic [2:0]         remain_q;
  logic               first_wait_q;
  logic               tx_start_q;
  logic [7:0]         tx_byte_q;
  logic [31:0]        adr_q;
  logic [31:0]        dat_q;
  logic               we_q;
  logic               cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      is_write_q   <= 1'b0;
      idx_q        <= '0;
      gap_q        <= '0;
      bus_cnt_q    <= '0;
      shift_q      <= '0;
      remain_q     <= '0;
      first_wait_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_received) begin
            if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
              is_write_q <= (rx_byte == CMD_WRITE);
              idx_q      <= '0;
              gap_q      <= '0;
              state_q    <= ADDR;
            end else begin
              shift_q  <= {RSP_BAD_CMD, 24'h0};
              remain_q <= 3'd1;
              state_q  <= TX_LOAD;
            end
          end
        end

        // A framing error abandons the partial command even if a byte arrives with it.
        ADDR, DATA: begin
          if (rx_error) begin
            state_q <= IDLE;
          end else if (rx_received) begin
            gap_q <= '0;
            idx_q <= idx_q + 2'd1;
            if (state_q == ADDR) begin
              adr_q <= {adr_q[23:0], rx_byte};
            end else begin
              dat_q <= {dat_q[23:0], rx_byte};
            end
            if (idx_q == 2'd3) begin
              if (state_q == ADDR && is_write_q) begin
                state_q <= DATA;
              end else begin
                state_q   <= BUS;
                cyc_q     <= 1'b1;
                we_q      <= is_write_q;
                bus_cnt_q <= '0;
              end
            end
          end else if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        BUS: begin
          if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= TX_LOAD;
            if (is_write_q) begin
              shift_q  <= {RSP_OK, 24'h0};
              remain_q <= 3'd1;
            end else begin
              shift_q  <= wb_dat_i;
              remain_q <= 3'd4;
            end
          end else if (bus_cnt_q == BUS_LAST) begin
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            shift_q  <= {RSP_BUS_ERR, 24'h0};
            remain_q <= 3'd1;
            state_q  <= TX_LOAD;
          end else begin
            bus_cnt_q <= bus_cnt_q + 1'b1;
          end
        end

        TX_LOAD: begin
          if (!tx_busy) begin
            tx_start_q   <= 1'b1;
            tx_byte_q    <= shift_q[31:24];
            first_wait_q <= 1'b1;
            state_q      <= TX_WAIT;
          end
        end

        // The UART only raises busy one cycle after accepting, so skip that cycle.
        TX_WAIT: begin
          if (first_wait_q) begin
            first_wait_q <= 1'b0;
          end else if (!tx_busy) begin
            remain_q <= remain_q - 3'd1;
            shift_q  <= {shift_q[23:0], 8'h00};
            state_q  <= (remain_q == 3'd1) ? IDLE : TX_LOAD;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder with a Wishbone slave model and a UART transmitter model.
module tb_uart_bus_responder;
  import uart_bus_pkg::*;

  localparam int BYTE_TO = 100;
  localparam int BUS_TO  = 255;

  logic        clk;
  logic        rst;
  logic        rx_received;
  logic [7:0]  rx_byte;
  logic        rx_error;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        busy;

  uart_bus_responder #(
    .BYTE_TIMEOUT(BYTE_TO),
    .BUS_TIMEOUT (BUS_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_received(rx_received),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } busTxn_t;

  busTxn_t     expBus[$];
  logic [7:0]  expTx[$];
  int          checks = 0;
  int          failures = 0;

  int          slaveDelay = 3;
  bit          slaveNoAck = 1'b0;
  logic [31:0] slaveRdData = 32'h0;
  int          lastCycLen = 0;
  int          cycEnds = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Wishbone slave: checks each new cycle against the scoreboard, acks after slaveDelay cycles.
  initial begin
    int  cnt;
    int  len;
    bit  prevCyc;
    busTxn_t t;
    cnt = 0; len = 0; prevCyc = 1'b0;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = $urandom;
      if (wb_cyc_o) begin
        if (!prevCyc) begin
          checkOutput("bus_stb", wb_stb_o, 1);
          checkOutput("bus_sel", wb_sel_o, 4'hF);
          checkOutput("bus_pending", expBus.size() > 0, 1);
          if (expBus.size() > 0) begin
            t = expBus.pop_front();
            checkOutput("bus_adr", wb_adr_o, t.adr);
            checkOutput("bus_we", wb_we_o, t.we);
            if (t.we) checkOutput("bus_dat", wb_dat_o, t.dat);
          end
          cnt = 0;
          len = 0;
        end
        cnt++;
        len++;
        if (!slaveNoAck && cnt == slaveDelay) begin
          wb_ack_i = 1'b1;
          wb_dat_i = slaveRdData;
        end
      end else if (prevCyc) begin
        lastCycLen = len;
        cycEnds++;
      end
      prevCyc = wb_cyc_o;
    end
  end

  // UART transmitter model plus tx scoreboard monitor.
  initial begin
    int busyLeft;
    bit prevStart;
    busyLeft = 0; prevStart = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        checkOutput("tx_start_pulse", prevStart, 0);
        checkOutput("tx_while_busy", tx_busy, 0);
        checkOutput("tx_pending", expTx.size() > 0, 1);
        if (expTx.size() > 0) checkOutput("tx_byte", tx_byte, expTx.pop_front());
        busyLeft = $urandom_range(8, 3);
        tx_busy = 1'b1;
      end else if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) tx_busy = 1'b0;
      end
      prevStart = tx_start;
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_byte = b;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Reference model: derives expected bus cycle and response bytes from the command.
  task automatic applyStimulus(input int kind, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [7:0] badByte, input int gapMax);
    busTxn_t t;
    if (kind == 2) begin
      expTx.push_back(RSP_BAD_CMD);
      sendByte(badByte, 0);
      return;
    end
    t.adr = adr;
    t.dat = dat;
    t.we  = (kind == 0);
    expBus.push_back(t);
    if (slaveNoAck) begin
      expTx.push_back(RSP_BUS_ERR);
    end else if (kind == 0) begin
      expTx.push_back(RSP_OK);
    end else begin
      for (int i = 3; i >= 0; i--) expTx.push_back(8'(slaveRdData >> (8 * i)));
    end
    sendByte((kind == 0) ? CMD_WRITE : CMD_READ, $urandom_range(gapMax, 0));
    for (int i = 3; i >= 0; i--) sendByte(8'(adr >> (8 * i)), $urandom_range(gapMax, 0));
    if (kind == 0)
      for (int i = 3; i >= 0; i--) sendByte(8'(dat >> (8 * i)), $urandom_range(gapMax, 0));
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (!(!busy && expTx.size() == 0 && !tx_busy && !wb_cyc_o) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idle", n < maxCycles, 1);
  endtask

  task automatic runCommand(input int kind, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [7:0] badByte, input int gapMax);
    int endsBefore;
    endsBefore = cycEnds;
    applyStimulus(kind, adr, dat, badByte, gapMax);
    waitIdle(3000);
    if (kind != 2) begin
      checkOutput("bus_cycles", cycEnds - endsBefore, 1);
      checkOutput("bus_len", lastCycLen, slaveNoAck ? BUS_TO : slaveDelay);
    end else begin
      checkOutput("no_bus_cycle", cycEnds - endsBefore, 0);
    end
    checkOutput("busy_after", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] bad;
    int kind;
    rst = 1'b1;
    rx_received = 1'b0;
    rx_byte = 8'h00;
    rx_error = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cyc", wb_cyc_o, 0);
    checkOutput("rst_stb", wb_stb_o, 0);
    checkOutput("rst_sel", wb_sel_o, 0);
    checkOutput("rst_we", wb_we_o, 0);
    checkOutput("rst_adr", wb_adr_o, 0);
    checkOutput("rst_dat", wb_dat_o, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_tx_byte", tx_byte, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed write and read");
    slaveDelay = 3;
    runCommand(0, 32'h0000_1000, 32'hDEAD_BEEF, 8'h00, 0);
    slaveDelay = 2;
    slaveRdData = 32'h1234_5678;
    runCommand(1, 32'h0000_0004, 32'h0, 8'h00, 2);

    $display("[TB] unknown command then read");
    runCommand(2, 32'h0, 32'h0, 8'h41, 0);
    slaveRdData = 32'h0BAD_F00D;
    runCommand(1, 32'h0000_0000, 32'h0, 8'h00, 0);

    $display("[TB] bus timeout");
    slaveNoAck = 1'b1;
    runCommand(1, 32'h8000_0010, 32'h0, 8'h00, 1);
    slaveNoAck = 1'b0;

    $display("[TB] gap timeout");
    sendByte(CMD_WRITE, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    repeat (94) @(negedge clk);
    checkOutput("gap_busy_before", busy, 1);
    repeat (8) @(negedge clk);
    checkOutput("gap_busy_after", busy, 0);
    checkOutput("gap_no_bus", expBus.size(), 0);
    slaveRdData = 32'h5555_AAAA;
    runCommand(1, 32'h0000_0020, 32'h0, 8'h00, 0);

    $display("[TB] rx_error handling");
    @(negedge clk);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    checkOutput("err_idle_busy", busy, 0);
    sendByte(CMD_READ, 0);
    sendByte(8'h00, 0);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    checkOutput("err_mid_addr_busy", busy, 0);
    sendByte(CMD_WRITE, 0);
    sendByte(8'h11, 0);
    rx_error = 1'b1;
    rx_received = 1'b1;
    rx_byte = CMD_READ;
    @(negedge clk);
    rx_error = 1'b0;
    rx_received = 1'b0;
    checkOutput("err_coincident_busy", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("err_no_tx", tx_busy, 0);

    $display("[TB] reset during bus cycle");
    slaveNoAck = 1'b1;
    applyStimulus(1, 32'h0000_00C0, 32'h0, 8'h00, 0);
    void'(expTx.pop_back());
    repeat (5) @(negedge clk);
    checkOutput("bus_active_before_rst", wb_cyc_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_cyc", wb_cyc_o, 0);
    checkOutput("rst_mid_stb", wb_stb_o, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_adr", wb_adr_o, 0);
    slaveNoAck = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("rst_mid_no_tx", tx_busy, 0);

    $display("[TB] bytes dropped while responding");
    slaveDelay = 2;
    slaveRdData = 32'hCAFE_F00D;
    applyStimulus(1, 32'h0000_0100, 32'h0, 8'h00, 0);
    begin
      int n;
      n = 0;
      while (!tx_busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      checkOutput("tx_began", tx_busy, 1);
    end
    sendByte(CMD_WRITE, 0);
    sendByte(8'h41, 0);
    sendByte(CMD_READ, 0);
    waitIdle(3000);
    repeat (20) @(negedge clk);
    checkOutput("drop_busy", busy, 0);
    checkOutput("drop_no_bus", expBus.size(), 0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(2, 0);
      slaveDelay = $urandom_range(6, 1);
      slaveRdData = $urandom;
      slaveNoAck = ($urandom_range(9, 0) == 0) && (kind != 2);
      do bad = 8'($urandom); while (bad == CMD_WRITE || bad == CMD_READ);
      runCommand(kind, $urandom, $urandom, bad, 6);
      slaveNoAck = 1'b0;
    end

    repeat (10) @(negedge clk);
    checkOutput("final_tx_drained", expTx.size(), 0);
    checkOutput("final_bus_drained", expBus.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
